// File: rtl/ct_share_arbiter.sv
// Two-requester burst round-robin front end for a shared ColorTransform.
// Forward pixels carry an owner tag through an in-order FIFO so that each
// returning grey pixel is steered back to the requester that issued it.
module ct_share_arbiter #(
    parameter  int unsigned BURST = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = 24,
    localparam int unsigned CNTW  = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_rgb0_vld,
    input  logic [PW-1:0]   i_rgb0_data,
    output logic            i_rgb0_busy,

    input  logic            i_rgb1_vld,
    input  logic [PW-1:0]   i_rgb1_data,
    output logic            i_rgb1_busy,

    output logic            o_ct_rgb_vld,
    output logic [PW-1:0]   o_ct_rgb_data,
    input  logic            o_ct_rgb_busy,

    input  logic            i_ct_grey_vld,
    input  logic [PW-1:0]   i_ct_grey_data,
    output logic            i_ct_grey_busy,

    output logic            o_grey0_vld,
    output logic [PW-1:0]   o_grey0_data,
    input  logic            o_grey0_busy,

    output logic            o_grey1_vld,
    output logic [PW-1:0]   o_grey1_data,
    input  logic            o_grey1_busy,

    output logic [CNTW-1:0] o_cnt0,
    output logic [CNTW-1:0] o_cnt1,
    output logic            o_err
);

    localparam int unsigned BW = $clog2(BURST) + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t          state, state_n;
    logic            owner, owner_n;
    logic            last, last_n;
    logic [BW-1:0]   bcnt, bcnt_n;

    logic [DEPTH-1:0] tag_mem;
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    tag_cnt;
    logic             tag_full, tag_empty, head;

    logic            vld_owner, req_other, req_last;
    logic            in_xfer, out_xfer;

    // Request view from the arbiter's point of view
    assign vld_owner = owner ? i_rgb1_vld : i_rgb0_vld;
    assign req_other = last  ? i_rgb0_vld : i_rgb1_vld;
    assign req_last  = last  ? i_rgb1_vld : i_rgb0_vld;

    assign tag_full  = (tag_cnt == CW'(DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign head      = tag_mem[rptr];

    // Forward path: owner stream muxed straight through, gated by tag space
    assign o_ct_rgb_vld  = (state == SERVE) & vld_owner & ~tag_full;
    assign o_ct_rgb_data = owner ? i_rgb1_data : i_rgb0_data;
    assign i_rgb0_busy   = (state != SERVE) | owner  | o_ct_rgb_busy | tag_full;
    assign i_rgb1_busy   = (state != SERVE) | ~owner | o_ct_rgb_busy | tag_full;
    assign in_xfer       = o_ct_rgb_vld & ~o_ct_rgb_busy;

    // Return path: FIFO head tag selects the destination
    assign o_grey0_vld    = i_ct_grey_vld & ~tag_empty & ~head;
    assign o_grey1_vld    = i_ct_grey_vld & ~tag_empty &  head;
    assign o_grey0_data   = i_ct_grey_data;
    assign o_grey1_data   = i_ct_grey_data;
    assign i_ct_grey_busy = tag_empty | (head ? o_grey1_busy : o_grey0_busy);
    assign out_xfer       = i_ct_grey_vld & ~i_ct_grey_busy;

    // Arbiter state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            bcnt  <= bcnt_n;
        end
    end

    // Arbiter next state: alternate preference, end burst on limit or idle owner
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                bcnt_n = '0;
                if (req_other) begin
                    owner_n = ~last;
                    state_n = SERVE;
                end else if (req_last) begin
                    owner_n = last;
                    state_n = SERVE;
                end
            end
            SERVE: begin
                if (in_xfer) begin
                    if (bcnt == BW'(BURST - 1)) begin
                        state_n = IDLE;
                        last_n  = owner;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                    end
                end else if (!vld_owner) begin
                    state_n = IDLE;
                    last_n  = owner;
                    bcnt_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tag FIFO: push on forward transfer, pop on return transfer
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag_mem <= '0;
            wptr    <= '0;
            rptr    <= '0;
            tag_cnt <= '0;
        end else begin
            if (in_xfer) begin
                tag_mem[wptr] <= owner;
                wptr          <= wptr + AW'(1);
            end
            if (out_xfer) begin
                rptr <= rptr + AW'(1);
            end
            case ({in_xfer, out_xfer})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Delivered-pixel counters and sticky orphan-pixel flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_cnt0 <= '0;
            o_cnt1 <= '0;
            o_err  <= 1'b0;
        end else begin
            if (out_xfer && !head) begin
                o_cnt0 <= o_cnt0 + CNTW'(1);
            end
            if (out_xfer && head) begin
                o_cnt1 <= o_cnt1 + CNTW'(1);
            end
            if (i_ct_grey_vld && tag_empty) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ct_share_arbiter.sv
// Bench for ct_share_arbiter: random requesters, a latency-queue model of
// ColorTransform, per-requester expected-grey scoreboards and issue-log checks.
module tb_ct_share_arbiter;

    localparam int unsigned BURST = 16;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv [2];
    logic [23:0] rd [2];
    logic        rb0, rb1;
    logic        ct_vld, ct_busy;
    logic [23:0] ct_data;
    logic        gv, g_busy_dut;
    logic [23:0] gd;
    logic        o0v, o1v;
    logic [23:0] o0d, o1d;
    logic        gb [2];
    logic [15:0] cnt0, cnt1;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int gen = 0;
    int quota [2] = '{0, 0};
    int prob [2] = '{0, 0};
    int sent [2] = '{0, 0};
    int sink_mode [2] = '{0, 0};
    int ct_busy_pct = 0;
    int ct_lat = 1;
    bit inject = 1'b0;
    int cyc = 0;
    int issued = 0;
    int delivered = 0;
    logic [15:0] mcnt0 = '0;
    logic [15:0] mcnt1 = '0;
    logic [23:0] exp_q0 [$];
    logic [23:0] exp_q1 [$];
    logic [23:0] ctq [$];
    int ctt [$];
    int iss_own [$];
    int iss_cyc [$];

    always #5 clk = ~clk;

    ct_share_arbiter #(.BURST(BURST), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rgb0_vld     (rv[0]),
        .i_rgb0_data    (rd[0]),
        .i_rgb0_busy    (rb0),
        .i_rgb1_vld     (rv[1]),
        .i_rgb1_data    (rd[1]),
        .i_rgb1_busy    (rb1),
        .o_ct_rgb_vld   (ct_vld),
        .o_ct_rgb_data  (ct_data),
        .o_ct_rgb_busy  (ct_busy),
        .i_ct_grey_vld  (gv),
        .i_ct_grey_data (gd),
        .i_ct_grey_busy (g_busy_dut),
        .o_grey0_vld    (o0v),
        .o_grey0_data   (o0d),
        .o_grey0_busy   (gb[0]),
        .o_grey1_vld    (o1v),
        .o_grey1_data   (o1d),
        .o_grey1_busy   (gb[1]),
        .o_cnt0         (cnt0),
        .o_cnt1         (cnt1),
        .o_err          (err)
    );

    // Stand-in for the ColorTransform colour-to-grey function
    function automatic logic [23:0] grey_fn(input logic [23:0] d);
        return {d[11:0], d[23:12]} ^ 24'hC35A96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Environment: drives requesters, CT model and sinks; logs issues; fills scoreboard
    initial begin : env
        int env_gen;
        bit took [2];
        bit t [2];
        bit xin, xout;
        int last_iss, last_own, run, own;
        env_gen = 0; took = '{1'b0, 1'b0}; last_iss = -10; last_own = 0; run = 0;
        rv[0] = 1'b0; rv[1] = 1'b0; rd[0] = '0; rd[1] = '0;
        ct_busy = 1'b0; gv = 1'b0; gd = '0; gb[0] = 1'b0; gb[1] = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (env_gen != gen) begin
                env_gen = gen;
                exp_q0.delete(); exp_q1.delete(); ctq.delete(); ctt.delete();
                sent = '{0, 0}; took = '{1'b0, 1'b0};
                rv[0] = 1'b0; rv[1] = 1'b0;
                issued = 0; run = 0; last_iss = -10;
            end
            for (int k = 0; k < 2; k++) begin
                if (!rv[k] || took[k]) begin
                    if (sent[k] < quota[k] && int'($urandom_range(99)) < prob[k]) begin
                        rv[k] = 1'b1;
                        rd[k] = 24'($urandom);
                    end else begin
                        rv[k] = 1'b0;
                    end
                end
                took[k] = 1'b0;
                gb[k] = (sink_mode[k] == 1) || (sink_mode[k] == 2 && $urandom_range(1) == 1);
            end
            ct_busy = int'($urandom_range(99)) < ct_busy_pct;
            if (inject) begin
                gv = 1'b1;
                gd = 24'h00BEEF;
            end else if (ctq.size() > 0 && (cyc - ctt[0]) >= ct_lat) begin
                gv = 1'b1;
                gd = ctq[0];
            end else begin
                gv = 1'b0;
            end
            #1;
            t[0] = rv[0] && !rb0;
            t[1] = rv[1] && !rb1;
            xin  = ct_vld && !ct_busy;
            xout = gv && !g_busy_dut && !inject;
            if (t[0] || t[1] || xin) begin
                check("issue_matches_request", 32'(t[0] | t[1]), 32'(xin));
                check("single_grant", 32'(t[0] & t[1]), 32'd0);
            end
            if (t[0]) exp_q0.push_back(grey_fn(rd[0]));
            if (t[1]) exp_q1.push_back(grey_fn(rd[1]));
            for (int k = 0; k < 2; k++) begin
                if (t[k]) begin
                    sent[k]++;
                    took[k] = 1'b1;
                end
            end
            if (t[0] || t[1]) begin
                own = t[1] ? 1 : 0;
                if (last_iss == cyc - 1) begin
                    check("no_switch_without_bubble", 32'(own), 32'(last_own));
                    run++;
                    check("burst_len_limit", 32'(run <= int'(BURST)), 32'd1);
                end else begin
                    run = 1;
                end
                last_iss = cyc;
                last_own = own;
                iss_own.push_back(own);
                iss_cyc.push_back(cyc);
            end
            if (xout && ctq.size() > 0) begin
                void'(ctq.pop_front());
                void'(ctt.pop_front());
            end
            if (xin) begin
                ctq.push_back(grey_fn(ct_data));
                ctt.push_back(cyc);
                issued++;
            end
            cyc++;
        end
    end

    // Monitor: pops expected grey pixels as the DUT delivers them
    initial begin : mon
        int mon_gen;
        logic [23:0] e;
        mon_gen = 0;
        forever begin
            @(negedge clk);
            #3;
            if (mon_gen != gen) begin
                mon_gen = gen;
                mcnt0 = '0;
                mcnt1 = '0;
                delivered = 0;
            end
            check("cnt0_track", 32'(cnt0), 32'(mcnt0));
            check("cnt1_track", 32'(cnt1), 32'(mcnt1));
            if (o0v && !gb[0]) begin
                check("grey0_expected", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    check("grey0_data", 32'(o0d), 32'(e));
                end
                mcnt0++;
                delivered++;
            end
            if (o1v && !gb[1]) begin
                check("grey1_expected", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    check("grey1_data", 32'(o1d), 32'(e));
                end
                mcnt1++;
                delivered++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        gen++;
        quota = '{0, 0};
        inject = 1'b0;
        cycles(3);
        rst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ct_vld"}, 32'(ct_vld), 32'd0);
        check({tag, "_grey0_vld"}, 32'(o0v), 32'd0);
        check({tag, "_grey1_vld"}, 32'(o1v), 32'd0);
        check({tag, "_rgb0_busy"}, 32'(rb0), 32'd1);
        check({tag, "_rgb1_busy"}, 32'(rb1), 32'd1);
        check({tag, "_ct_grey_busy"}, 32'(g_busy_dut), 32'd1);
        check({tag, "_cnt0"}, 32'(cnt0), 32'd0);
        check({tag, "_cnt1"}, 32'(cnt1), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            done = sent[0] >= quota[0] && sent[1] >= quota[1] &&
                   exp_q0.size() == 0 && exp_q1.size() == 0;
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain_within_budget", 32'(done), 32'd1);
    endtask

    // Main sequence
    initial begin : main
        int s, c0, first, expo;
        bit found;

        // Reset values
        cycles(3);
        #4;
        check_reset_state("in_reset");
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        #4;
        check_reset_state("after_reset");

        // Grey pixel with no tag outstanding
        @(negedge clk);
        inject = 1'b1;
        cycles(3);
        #4;
        check("err_set", 32'(err), 32'd1);
        check("err_ct_grey_busy", 32'(g_busy_dut), 32'd1);
        check("err_no_grey0", 32'(o0v), 32'd0);
        check("err_no_grey1", 32'(o1v), 32'd0);
        @(negedge clk);
        inject = 1'b0;
        cycles(5);
        #4;
        check("err_sticky", 32'(err), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        gen++;
        #4;
        check("err_cleared_by_reset", 32'(err), 32'd0);
        cycles(2);
        rst = 1'b1;

        // Owner stops after 3 pixels; other requester gets a fresh burst
        sink_mode = '{0, 0}; ct_busy_pct = 0; ct_lat = 3; prob = '{100, 100};
        @(negedge clk);
        s = iss_own.size();
        c0 = cyc;
        quota[0] = sent[0] + 3;
        quota[1] = sent[1] + 16;
        wait_drain(300);
        check("drop_issue_count", 32'(iss_own.size() - s), 32'd19);
        if (iss_own.size() >= s + 19) begin
            for (int i = 0; i < 19; i++) begin
                check("drop_issue_owner", 32'(iss_own[s + i]), (i < 3) ? 32'd0 : 32'd1);
            end
            check("grant_latency", 32'(iss_cyc[s] - c0), 32'd1);
            check("drop_regrant_gap", 32'(iss_cyc[s + 3] - iss_cyc[s + 2]), 32'd3);
            check("drop_burst_restart", 32'(iss_cyc[s + 18] - iss_cyc[s + 3]), 32'd15);
        end

        // Single requester, 40 pixels: bubble after every 16
        apply_reset();
        ct_lat = 5; prob = '{100, 0};
        @(negedge clk);
        s = iss_own.size();
        quota[0] = sent[0] + 40;
        wait_drain(500);
        check("single_issue_count", 32'(iss_own.size() - s), 32'd40);
        if (iss_own.size() >= s + 40) begin
            for (int i = 1; i < 40; i++) begin
                check("single_issue_owner", 32'(iss_own[s + i]), 32'd0);
                check("single_issue_gap", 32'(iss_cyc[s + i] - iss_cyc[s + i - 1]),
                      (i % 16 == 0) ? 32'd2 : 32'd1);
            end
        end
        #4;
        check("single_cnt0", 32'(cnt0), 32'd40);
        check("single_cnt1", 32'(cnt1), 32'd0);

        // Both requesters continuous: alternating 16-pixel bursts
        ct_lat = int'($urandom_range(12, 1)); ct_busy_pct = 30;
        sink_mode = '{2, 2}; prob = '{100, 100};
        @(negedge clk);
        s = iss_own.size();
        first = 1 - iss_own[s - 1];
        quota[0] = sent[0] + 64;
        quota[1] = sent[1] + 64;
        wait_drain(3000);
        check("both_issue_count", 32'(iss_own.size() - s), 32'd128);
        if (iss_own.size() >= s + 128) begin
            for (int i = 0; i < 128; i++) begin
                expo = ((i / 16) % 2 == 0) ? first : 1 - first;
                check("both_issue_owner", 32'(iss_own[s + i]), 32'(expo));
            end
        end

        // Requester-1 sink stalled: tag FIFO fills, both requesters held off
        ct_lat = 2; ct_busy_pct = 0; sink_mode = '{0, 1};
        @(negedge clk);
        quota[0] = sent[0] + 20;
        quota[1] = sent[1] + 20;
        cycles(50);
        #4;
        check("fill_in_flight", 32'(issued - delivered), 32'(DEPTH));
        check("fill_rgb0_busy", 32'(rb0), 32'd1);
        check("fill_rgb1_busy", 32'(rb1), 32'd1);
        check("fill_ct_grey_busy", 32'(g_busy_dut), 32'd1);
        @(negedge clk);
        sink_mode = '{0, 0};
        wait_drain(500);

        // Random traffic
        ct_lat = int'($urandom_range(10, 1)); ct_busy_pct = 25;
        sink_mode = '{2, 2}; prob = '{60, 40};
        @(negedge clk);
        quota[0] = sent[0] + 150;
        quota[1] = sent[1] + 150;
        wait_drain(5000);
        #4;
        check("random_all_delivered", 32'(issued - delivered), 32'd0);

        // Reset mid-burst with 5 tags outstanding
        ct_lat = 1; ct_busy_pct = 0; sink_mode = '{1, 1}; prob = '{100, 0};
        @(negedge clk);
        quota[0] = sent[0] + 30;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (issued - delivered == 5) found = 1'b1;
        end
        check("mid_burst_five_tags", 32'(found), 32'd1);
        rst = 1'b0;
        gen++;
        quota = '{0, 0};
        #4;
        check_reset_state("mid_reset");
        cycles(3);
        rst = 1'b1;

        // Recovery after reset
        sink_mode = '{0, 0}; prob = '{100, 100};
        @(negedge clk);
        quota[0] = sent[0] + 10;
        quota[1] = sent[1] + 10;
        wait_drain(300);
        #4;
        check("recover_cnt0", 32'(cnt0), 32'd10);
        check("recover_cnt1", 32'(cnt1), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
